// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Holds the FSM state encoding, the requester identity and the latched access record.
// No logic; imported by mem_arb and mem_arb_pick.
package mem_arb_pkg;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 3;
  localparam int AW             = 16;
  localparam int DW             = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Access captured at grant time; drives the memory bus for the whole BUSY window.
  typedef struct packed {
    owner_t        owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: chooses the winner between fetch and data requests, data first unless fetch is starved.
// Latency: purely combinational, no state.
// Backpressure: none here; the caller only applies the decision while idle.
// Ports: if_req/d_req pending requests, starve_cnt current starvation count,
//        grant_vld any request pending, grant_own winning requester.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          grant_vld,
  output owner_t        grant_own
);

  logic force_if;

  always_comb begin
    // Fetch has lost STARVE_MAX times in a row: it takes this slot if it wants it.
    force_if  = if_req && (starve_cnt == SW'(STARVE_MAX));
    grant_vld = if_req || d_req;
    grant_own = (d_req && !force_if) ? OWN_D : OWN_IF;
  end

endmodule

// File: rtl/mem_arb.sv
// Purpose: shares one single-port word memory between instruction fetch and data load/store.
// Latency: request sampled in IDLE -> rdy pulse MEM_LAT+1 cycles later; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req/addr/data until their rdy pulse; the loser simply waits.
// Ports: clk/rst_n (sync, active-low); if_req/if_addr -> if_rdy/if_data;
//        d_re/d_we/d_addr/d_wdata -> d_rdy/d_rdata; mem_addr/mem_re/mem_we/mem_wdata <- mem_rdata.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_rdy,
  output logic [DW-1:0] if_data,
  input  logic          d_re,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_rdy,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state_q, state_d;
  acc_t          acc_q, acc_d;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;

  logic          grant_vld;
  owner_t        grant_own;
  logic          grant_take;
  logic          lat_last;

  logic          mem_re_d, mem_we_d;
  logic          if_rdy_d, d_rdy_d;
  logic          cap_if, cap_d;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_re | d_we),
    .starve_cnt (starve_cnt),
    .grant_vld  (grant_vld),
    .grant_own  (grant_own)
  );

  assign grant_take = (state_q == IDLE) && grant_vld;
  assign lat_last   = (lat_cnt == LW'(MEM_LAT));

  // The bus is driven straight from the latched access record, so it is stable for
  // the whole BUSY window regardless of what the requester does with its inputs.
  assign mem_addr  = acc_q.addr;
  assign mem_wdata = acc_q.wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = BUSY;
      BUSY:    if (lat_last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and capture enables
  always_comb begin
    acc_d    = acc_q;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    if_rdy_d = 1'b0;
    d_rdy_d  = 1'b0;
    cap_if   = 1'b0;
    cap_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          acc_d.owner = grant_own;
          if (grant_own == OWN_D) begin
            // Read and write together is a write; the load side is ignored.
            acc_d.we    = d_we;
            acc_d.addr  = d_addr;
            acc_d.wdata = d_wdata;
          end else begin
            acc_d.we    = 1'b0;
            acc_d.addr  = if_addr;
          end
          mem_re_d = !acc_d.we;
          mem_we_d = acc_d.we;
        end
      end
      BUSY: begin
        if (!lat_last) begin
          mem_re_d = mem_re;
          mem_we_d = mem_we;
        end else begin
          // mem_rdata is valid now; the rdy pulse lands in DONE alongside the captured data.
          if_rdy_d = (acc_q.owner == OWN_IF);
          d_rdy_d  = (acc_q.owner == OWN_D);
          cap_if   = if_rdy_d && !acc_q.we;
          cap_d    = d_rdy_d && !acc_q.we;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      if_rdy     <= 1'b0;
      d_rdy      <= 1'b0;
      if_data    <= '0;
      d_rdata    <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      acc_q  <= acc_d;
      mem_re <= mem_re_d;
      mem_we <= mem_we_d;
      if_rdy <= if_rdy_d;
      d_rdy  <= d_rdy_d;
      if (cap_if) if_data <= mem_rdata;
      if (cap_d)  d_rdata <= mem_rdata;

      if (grant_take)                          lat_cnt <= LW'(1);
      else if ((state_q == BUSY) && !lat_last) lat_cnt <= lat_cnt + LW'(1);
      else                                     lat_cnt <= '0;

      // Only a data win over a waiting fetch counts as a loss for fetch.
      if (grant_take) begin
        if (grant_own == OWN_IF)
          starve_cnt <= '0;
        else if (if_req && (starve_cnt != SW'(STARVE_MAX)))
          starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

  localparam int LAT   = 3;
  localparam int SMAX  = 3;
  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_re = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_rdy, d_rdy, mem_re, mem_we;
  logic [15:0] if_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arb #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // Behavioural memory seen by the DUT, and the bench's own expectation of its contents.
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a * 40503) ^ 16'h5A5A;
    mem[16'h0010] = 16'hA5C3;
    mem[16'h8000] = 16'h1234;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
    end
  end

  int n_vec = 0, n_err = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc += 1; end

  // Monitor: completion log and strobe-window records.
  bit          own_q[$];
  logic [15:0] dat_q[$];
  int          rcyc_q[$];
  int          run_len_q[$];
  logic [15:0] run_addr_q[$];
  bit          run_we_q[$], run_re_q[$], run_stab_q[$];
  int          if_pulses = 0, d_pulses = 0, re_cycles = 0;
  bit          in_run = 0, r_we, r_re, r_stab;
  int          r_len;
  logic [15:0] r_addr, r_wd;

  initial forever begin
    @(negedge clk);
    if (if_rdy === 1'b1) begin own_q.push_back(1'b0); dat_q.push_back(if_data); rcyc_q.push_back(cyc); if_pulses++; end
    if (d_rdy === 1'b1)  begin own_q.push_back(1'b1); dat_q.push_back(d_rdata); rcyc_q.push_back(cyc); d_pulses++; end
    if (mem_re === 1'b1) re_cycles++;
    if (mem_re === 1'b1 || mem_we === 1'b1) begin
      if (!in_run) begin
        in_run = 1; r_len = 1; r_addr = mem_addr; r_wd = mem_wdata; r_we = mem_we; r_re = mem_re; r_stab = 1;
      end else begin
        r_len++;
        if ({mem_addr, mem_wdata, mem_we, mem_re} !== {r_addr, r_wd, r_we, r_re}) r_stab = 0;
      end
    end else if (in_run) begin
      in_run = 0;
      run_len_q.push_back(r_len); run_addr_q.push_back(r_addr);
      run_we_q.push_back(r_we); run_re_q.push_back(r_re); run_stab_q.push_back(r_stab);
    end
  end

  // Reference model state: expected memory, expected load register, expected results per port.
  logic [15:0] ref_d_rdata = '0;
  logic [15:0] exp_if_q[$], exp_d_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    own_q.delete(); dat_q.delete(); rcyc_q.delete();
    run_len_q.delete(); run_addr_q.delete(); run_we_q.delete(); run_re_q.delete(); run_stab_q.delete();
    exp_if_q.delete(); exp_d_q.delete();
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n = 0; if_req = 0; d_re = 0; d_we = 0;
    repeat (n) @(negedge clk);
    rst_n = 1;
    ref_d_rdata = '0;
    clear_logs();
  endtask

  // Fetch port driver; call at a negedge. Holds the request until if_rdy (bounded).
  task automatic if_access(input logic [15:0] a, input bit keep, output int lat, output bit ok);
    int t0; bit got;
    t0 = cyc; got = 0;
    if_req = 1; if_addr = a;
    exp_if_q.push_back(ref_mem[a]);
    for (int k = 0; k < BOUND && !got; k++) begin
      @(negedge clk);
      got = (if_rdy === 1'b1);
    end
    lat = cyc - t0; ok = got;
    if (!keep || !got) if_req = 0;
  endtask

  // Data port driver; call at a negedge. scramble changes addr/wdata once the access is under way.
  task automatic d_access(input bit re, input bit we, input logic [15:0] a, input logic [15:0] wd,
                          input bit keep, input bit scramble, output int lat, output bit ok);
    int t0; bit got;
    t0 = cyc; got = 0;
    d_re = re; d_we = we; d_addr = a; d_wdata = wd;
    if (!we) ref_d_rdata = ref_mem[a];
    exp_d_q.push_back(ref_d_rdata);
    for (int k = 0; k < BOUND && !got; k++) begin
      @(negedge clk);
      got = (d_rdy === 1'b1);
      if (k == 0 && scramble && !got) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
    end
    lat = cyc - t0; ok = got;
    if (got && we) ref_mem[a] = wd;
    if (!keep || !got) begin d_re = 0; d_we = 0; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if ({if_rdy, d_rdy, mem_re, mem_we} !== 4'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 0000", {if_rdy, d_rdy, mem_re, mem_we}); end
    n_vec++; if (if_data !== 16'h0)   begin n_err++; $display("FAIL reset_if_data: got %h want 0000", if_data); end
    n_vec++; if (d_rdata !== 16'h0)   begin n_err++; $display("FAIL reset_d_rdata: got %h want 0000", d_rdata); end
    n_vec++; if (mem_addr !== 16'h0)  begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_vec++; if (mem_wdata !== 16'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
    rst_n = 1;
  endtask

  task automatic test_lone_fetch();
    int l, dp; bit ok;
    clear_logs(); dp = d_pulses;
    @(negedge clk);
    if_access(16'h0010, 0, l, ok);
    @(negedge clk);
    n_vec++; if (!ok || l != LAT + 1) begin n_err++; $display("FAIL fetch_latency: got %0d (ok=%0d) want %0d", l, ok, LAT + 1); end
    n_vec++; if (if_data !== 16'hA5C3) begin n_err++; $display("FAIL fetch_data: got %h want a5c3", if_data); end
    n_vec++; if (d_pulses != dp) begin n_err++; $display("FAIL fetch_no_d_rdy: got %0d pulses want 0", d_pulses - dp); end
    n_vec++;
    if (run_len_q.size() != 1 || run_len_q[0] != LAT || run_re_q[0] != 1 || run_we_q[0] != 0 || run_addr_q[0] !== 16'h0010) begin
      n_err++; $display("FAIL fetch_strobes: runs=%0d len=%0d want 1 run of %0d reads at 0010", run_len_q.size(), (run_len_q.size() > 0) ? run_len_q[0] : -1, LAT);
    end
  endtask

  task automatic test_priority();
    int li, ld; bit oki, okd; logic [15:0] a;
    clear_logs(); a = 16'h2000 + 16'($urandom_range(0, 255));
    @(negedge clk);
    fork
      if_access(a, 0, li, oki);
      d_access(1, 0, 16'h8000, 16'h0, 0, 0, ld, okd);
    join
    @(negedge clk);
    n_vec++; if (!okd || ld != LAT + 1) begin n_err++; $display("FAIL prio_d_latency: got %0d want %0d", ld, LAT + 1); end
    n_vec++; if (!oki || li != 2 * LAT + 3) begin n_err++; $display("FAIL prio_if_latency: got %0d want %0d", li, 2 * LAT + 3); end
    n_vec++;
    if (own_q.size() != 2 || own_q[0] != 1 || own_q[1] != 0) begin
      n_err++; $display("FAIL prio_order: got %0d completions, first owner %0d want data then fetch", own_q.size(), (own_q.size() > 0) ? int'(own_q[0]) : -1);
    end else begin
      n_vec++; if (dat_q[0] !== 16'h1234) begin n_err++; $display("FAIL prio_d_rdata: got %h want 1234", dat_q[0]); end
      n_vec++; if (dat_q[1] !== exp_if_q[0]) begin n_err++; $display("FAIL prio_if_data: got %h want %h", dat_q[1], exp_if_q[0]); end
    end
  endtask

  task automatic test_starvation(input int nd, input int ni);
    int st, rd, ri, l1, l2; bit o1, o2, ok_all; bit exp_own[$]; logic [15:0] e;
    apply_reset(2);
    // Both ports always pending while they have work: apply the priority rule slot by slot.
    st = 0; rd = nd; ri = ni;
    while (rd > 0 || ri > 0) begin
      if (rd > 0 && !(ri > 0 && st == SMAX)) begin
        exp_own.push_back(1'b1); rd--;
        if (ri > 0 && st < SMAX) st++;
      end else begin
        exp_own.push_back(1'b0); ri--; st = 0;
      end
    end
    ok_all = 1;
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < ni; i++) begin if_access(16'($urandom), (i < ni - 1), l1, o1); if (!o1) ok_all = 0; end
      end
      begin
        @(negedge clk);
        for (int i = 0; i < nd; i++) begin d_access(1, 0, 16'($urandom), 16'h0, (i < nd - 1), 0, l2, o2); if (!o2) ok_all = 0; end
      end
    join
    @(negedge clk);
    n_vec++; if (!ok_all) begin n_err++; $display("FAIL starve_timeout: a request never completed"); end
    n_vec++;
    if (own_q.size() != exp_own.size()) begin
      n_err++; $display("FAIL starve_count: got %0d completions want %0d", own_q.size(), exp_own.size());
    end else begin
      for (int i = 0; i < exp_own.size(); i++) begin
        n_vec++; if (own_q[i] != exp_own[i]) begin n_err++; $display("FAIL starve_order[%0d]: got owner %0d want %0d", i, own_q[i], exp_own[i]); end
        e = own_q[i] ? exp_d_q.pop_front() : exp_if_q.pop_front();
        n_vec++; if (dat_q[i] !== e) begin n_err++; $display("FAIL starve_data[%0d]: got %h want %h", i, dat_q[i], e); end
        if (i > 0) begin
          n_vec++; if (rcyc_q[i] - rcyc_q[i-1] != LAT + 2) begin n_err++; $display("FAIL starve_spacing[%0d]: got %0d want %0d", i, rcyc_q[i] - rcyc_q[i-1], LAT + 2); end
        end
      end
    end
  endtask

  task automatic test_write();
    int l, rc; bit ok; logic [15:0] prev;
    clear_logs(); prev = ref_d_rdata; rc = re_cycles;
    @(negedge clk);
    d_access(0, 1, 16'h0042, 16'hBEEF, 0, 1, l, ok);
    @(negedge clk);
    n_vec++; if (!ok || l != LAT + 1) begin n_err++; $display("FAIL wr_latency: got %0d want %0d", l, LAT + 1); end
    n_vec++;
    if (run_len_q.size() != 1 || run_len_q[0] != LAT || run_we_q[0] != 1 || run_re_q[0] != 0 || run_stab_q[0] != 1 || run_addr_q[0] !== 16'h0042) begin
      n_err++; $display("FAIL wr_strobes: runs=%0d len=%0d stable=%0d want 1 stable write of %0d cycles at 0042",
                        run_len_q.size(), (run_len_q.size() > 0) ? run_len_q[0] : -1, (run_len_q.size() > 0) ? int'(run_stab_q[0]) : -1, LAT);
    end
    n_vec++; if (re_cycles != rc) begin n_err++; $display("FAIL wr_no_re: got %0d read cycles want 0", re_cycles - rc); end
    n_vec++; if (d_rdata !== prev) begin n_err++; $display("FAIL wr_d_rdata_kept: got %h want %h", d_rdata, prev); end
    d_access(1, 0, 16'h0042, 16'h0, 0, 0, l, ok);
    @(negedge clk);
    n_vec++; if (!ok || d_rdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_readback: got %h want beef", d_rdata); end
  endtask

  task automatic test_rw_both();
    int l, rc; bit ok; logic [15:0] prev, a, wd;
    clear_logs(); prev = ref_d_rdata; rc = re_cycles;
    a = 16'h3000 + 16'($urandom_range(0, 255)); wd = 16'($urandom);
    @(negedge clk);
    d_access(1, 1, a, wd, 0, 0, l, ok);
    @(negedge clk);
    n_vec++; if (re_cycles != rc) begin n_err++; $display("FAIL rw_no_re: got %0d read cycles want 0", re_cycles - rc); end
    n_vec++; if (run_we_q.size() != 1 || run_we_q[0] != 1) begin n_err++; $display("FAIL rw_is_write: got %0d write runs want 1", run_we_q.size()); end
    n_vec++; if (!ok || d_rdata !== prev) begin n_err++; $display("FAIL rw_d_rdata_kept: got %h want %h", d_rdata, prev); end
    d_access(1, 0, a, 16'h0, 0, 0, l, ok);
    @(negedge clk);
    n_vec++; if (!ok || d_rdata !== wd) begin n_err++; $display("FAIL rw_readback: got %h want %h", d_rdata, wd); end
  endtask

  task automatic test_reset_mid();
    int l, ip, dp; bit ok; logic [15:0] a;
    clear_logs(); ip = if_pulses; dp = d_pulses; a = 16'($urandom);
    @(negedge clk);
    if_req = 1; if_addr = a;
    @(negedge clk);
    n_vec++; if (mem_re !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got mem_re %b want 1", mem_re); end
    @(negedge clk);
    rst_n = 0; if_req = 0;
    @(negedge clk);
    n_vec++; if ({if_rdy, d_rdy, mem_re, mem_we} !== 4'b0) begin n_err++; $display("FAIL rstmid_strobes: got %b want 0000", {if_rdy, d_rdy, mem_re, mem_we}); end
    n_vec++; if ({if_data, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin n_err++; $display("FAIL rstmid_values: got %h want 0", {if_data, d_rdata, mem_addr, mem_wdata}); end
    repeat (2) @(negedge clk);
    rst_n = 1; ref_d_rdata = '0;
    @(negedge clk);
    n_vec++; if (if_pulses != ip || d_pulses != dp) begin n_err++; $display("FAIL rstmid_no_rdy: got %0d pulses want 0", if_pulses - ip + d_pulses - dp); end
    clear_logs();
    if_access(a ^ 16'h00FF, 0, l, ok);
    @(negedge clk);
    n_vec++; if (!ok || l != LAT + 1 || if_data !== exp_if_q[0]) begin n_err++; $display("FAIL rstmid_fresh: got lat %0d data %h want lat %0d data %h", l, if_data, LAT + 1, exp_if_q[0]); end
  endtask

  task automatic test_random(input int n);
    int op, l; bit ok, eo; logic [15:0] a, wd, e;
    for (int i = 0; i < n; i++) begin
      clear_logs();
      op = $urandom_range(0, 3);
      a  = 16'h0100 + 16'($urandom_range(0, 15));
      wd = 16'($urandom);
      eo = (op != 0);
      case (op)
        0:       if_access(a, 0, l, ok);
        1:       d_access(1, 0, a, 16'h0, 0, 0, l, ok);
        2:       d_access(0, 1, a, wd, 0, 0, l, ok);
        default: d_access(1, 1, a, wd, 0, 0, l, ok);
      endcase
      @(negedge clk);
      n_vec++; if (!ok || l != LAT + 1) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, l, LAT + 1); end
      n_vec++;
      if (own_q.size() != 1 || own_q[0] != eo) begin
        n_err++; $display("FAIL rand_owner[%0d]: got %0d completions want 1 for owner %0d", i, own_q.size(), eo);
      end else begin
        e = eo ? exp_d_q[0] : exp_if_q[0];
        n_vec++; if (dat_q[0] !== e) begin n_err++; $display("FAIL rand_data[%0d] op %0d: got %h want %h", i, op, dat_q[0], e); end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ref_mem[a] = 16'(a * 40503) ^ 16'h5A5A;
    ref_mem[16'h0010] = 16'hA5C3;
    ref_mem[16'h8000] = 16'h1234;
    test_reset();
    test_lone_fetch();
    test_priority();
    test_starvation(9, 3);
    test_starvation($urandom_range(4, 10), $urandom_range(1, 4));
    test_write();
    test_rw_both();
    test_reset_mid();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter sharing one 16-bit word-addressed memory between the instruction-fetch port and the data (load/store) port of the pipelined core. Sequences each access through a fixed-latency state machine, gives data priority with bounded instruction starvation, and returns a one-cycle ready pulse to the winning requester. Sits between the fetch/memory pipeline stages and the unified memory array.

## Interface
- MEM_LAT, 1: memory read/write latency in cycles, 1..7.
- STARVE_MAX, 3: consecutive instruction losses tolerated before instruction is forced to win, 1..15.

- clk  input  1  core clock, rising-edge.
- rst_n  input  1  reset; synchronous and active-low.
- if_req  input  1  fetch request; held with if_addr until if_rdy.
- if_addr  input  16  fetch word address.
- if_rdy  output  1  one-cycle pulse: if_data valid.
- if_data  output  16  fetched instruction, registered.
- d_re  input  1  data read request; held until d_rdy.
- d_we  input  1  data write request; held until d_rdy.
- d_addr  input  16  data word address.
- d_wdata  input  16  store data.
- d_rdy  output  1  one-cycle pulse: read data valid or write complete.
- d_rdata  output  16  load data, registered.
- mem_addr  output  16  memory address, registered.
- mem_re  output  1  memory read strobe.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data, valid in last BUSY cycle.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: sample requests at rising edge. Data request (d_re|d_we) wins unless starve_cnt == STARVE_MAX, in which case a pending if_req wins. Grant latches owner, address, write data, and op; go BUSY. No request: stay IDLE.
- d_re and d_we both high: treated as write; d_rdata unchanged.
- BUSY: mem_addr/mem_re/mem_we/mem_wdata held stable for MEM_LAT cycles; lat_cnt counts 1..MEM_LAT. On the edge ending the last BUSY cycle: if read, capture mem_rdata into if_data or d_rdata per owner; go DONE.
- DONE: owner's rdy high for exactly this cycle; mem strobes low; no grant made. Next edge -> IDLE.
- starve_cnt: increments when data wins in IDLE while if_req is high; clears when instruction is granted; saturates at STARVE_MAX.
- Requests arriving during BUSY/DONE wait; requesters hold them. Requester deasserts during DONE (rdy cycle) or presents next request.
- Writes: d_rdy pulses in DONE; d_rdata keeps its previous value.

## Timing
- Request high at edge E0 (IDLE) -> strobes high cycles E0+1..E0+MEM_LAT -> rdy high cycle after edge E0+MEM_LAT+1 -> IDLE after E0+MEM_LAT+2.
- Latency request-sample to rdy: MEM_LAT+1 cycles; throughput one access per MEM_LAT+2 cycles.
- All outputs registered; no combinational input-to-output path.
- Reset values: state IDLE, if_rdy 0, d_rdy 0, if_data 0, d_rdata 0, mem_addr 0, mem_re 0, mem_we 0, mem_wdata 0, starve_cnt 0, lat_cnt 0.
- Reset mid-access: transaction abandoned, no rdy pulse, strobes low the cycle after reset is sampled; a pending write may be partially applied by memory.
- Address/data change on the requesting port during BUSY has no effect (latched at grant).

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY, DONE), owner enum (OWN_IF, OWN_D), default MEM_LAT/STARVE_MAX constants.
- lat_cnt width $clog2(MEM_LAT+1); starve_cnt width $clog2(STARVE_MAX+1).
- One combinational sub-module natural: mem_arb_pick (priority + starvation decision); counters and FSM stay in mem_arb.

## Test plan
- Lone fetch, MEM_LAT=1, if_addr=0x0010, mem returns 0xA5C3 -> if_rdy pulses 2 cycles after sampling, if_data=0xA5C3, d_rdy never high.
- Simultaneous if_req and d_re (d_addr=0x8000, data 0x1234) -> data granted first, d_rdata=0x1234; fetch granted next access.
- Continuous d_re plus held if_req, STARVE_MAX=3 -> three data grants, then instruction grant, starve_cnt back to 0, pattern repeats.
- d_we with d_wdata=0xBEEF to 0x0042, MEM_LAT=3 -> mem_we high exactly 3 cycles with stable addr/data, d_rdy pulse, d_rdata unchanged; readback returns 0xBEEF.
- rst_n low during BUSY -> no rdy pulse, strobes low next cycle, all outputs at reset values, fresh request after release completes normally.
- d_re and d_we together -> handled as write, mem_re never asserted.
